// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner: FSM states,
// key-code width helper and the vending panel's key codes.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEB,
        HELD,
        REL
    } kp_state_e;

    // A 1x1 matrix still needs a one-bit code port.
    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    // Vending panel on the 4x4 board: code = col_idx*4 + row_idx.
    localparam int KEY_W = 4;
    localparam logic [KEY_W-1:0] KEY_0      = 4'd0;
    localparam logic [KEY_W-1:0] KEY_1      = 4'd1;
    localparam logic [KEY_W-1:0] KEY_2      = 4'd2;
    localparam logic [KEY_W-1:0] KEY_3      = 4'd3;
    localparam logic [KEY_W-1:0] KEY_4      = 4'd4;
    localparam logic [KEY_W-1:0] KEY_5      = 4'd5;
    localparam logic [KEY_W-1:0] KEY_6      = 4'd6;
    localparam logic [KEY_W-1:0] KEY_7      = 4'd7;
    localparam logic [KEY_W-1:0] KEY_BACK   = 4'd8;
    localparam logic [KEY_W-1:0] KEY_ENSURE = 4'd9;

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through key event FIFO with a registered head word.
// A push into a full FIFO only lands when a pop happens in the same cycle.
module keypad_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = head_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        head_d = head_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        // Head follows the next read slot; the word being written this cycle
        // is not in mem_q yet, so it is forwarded when it becomes the head.
        if (wptr_d != rptr_d) begin
            head_d = (do_push && (wptr_q == rptr_d)) ? wdata : mem_q[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// ROWS x COLS keypad scanner: tick-paced column scan, press/release debounce,
// event FIFO. Define KEYPAD_REPEAT_EN to auto-repeat a held key's code.
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [ROWS-1:0]                   row,
    output logic [COLS-1:0]                   col,
    output logic [code_width(ROWS, COLS)-1:0] key_code,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic                              key_held,
    output logic                              overflow,
    input  logic                              clr_overflow
);
    localparam int CW  = code_width(ROWS, COLS);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW  = $clog2(TICK_DIV);
    localparam int DW  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || FIFO_DEPTH < 2 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("matrix_keypad_scanner: invalid parameter set");
    end

    logic [ROWS-1:0] row_meta_q, row_meta_d;
    logic [ROWS-1:0] row_sync_q, row_sync_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick_q, tick_d;
    kp_state_e       state_q, state_d;
    logic [CLW-1:0]  c_q, c_d;
    logic [RW-1:0]   r_q, r_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            held_q, held_d;
    logic            push_q, push_d;
    logic [CW-1:0]   code_q, code_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   low_idx;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW     = $clog2(REP_MAX + 1);
    localparam logic [RPW-1:0] REP_FIRST_LAST = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] REP_NEXT_LAST  = RPW'(REPEAT_RATE - 1);

    logic [RPW-1:0] rep_q, rep_d;
    logic           rep_first_q, rep_first_d;
`endif

    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;
        tick_d     = 1'b0;
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_sync_q[i]) low_idx = RW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        push_d  = 1'b0;
        code_d  = CW'(int'(c_q) * ROWS + int'(r_q));
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (tick_q) begin
            case (state_q)
                IDLE: begin
                    if (row_sync_q != '1) begin
                        state_d = SCAN;
                        c_d     = '0;
                    end
                end
                SCAN: begin
                    if (row_sync_q != '1) begin
                        state_d = DEB;
                        r_d     = low_idx;
                        cnt_d   = '0;
                    end else if (c_q == COL_LAST) begin
                        state_d = IDLE;
                    end else begin
                        c_d = c_q + CLW'(1);
                    end
                end
                DEB: begin
                    if (row_sync_q[r_q]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = HELD;
                        push_d  = 1'b1;
                        held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
                        rep_first_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                HELD: begin
                    if (row_sync_q[r_q]) begin
                        state_d = REL;
                        cnt_d   = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q == (rep_first_q ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
                        push_d      = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_d = rep_q + RPW'(1);
                    end
`endif
                end
                REL: begin
                    // Any low tick during release restarts the stability window.
                    if (!row_sync_q[r_q]) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = IDLE;
                        held_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop = key_valid && key_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (push_q && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            state_q    <= IDLE;
            c_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            held_q     <= 1'b0;
            push_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            c_q        <= c_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            push_q     <= push_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        code_q <= code_d;
    end

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_q),
        .wdata (code_q),
        .pop   (pop),
        .rdata (key_code),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Idle drives every column so any key press pulls a row low.
    assign col       = (state_q == IDLE) ? '0 : ~(COLS'(1) << c_q);
    assign key_valid = !fifo_empty;
    assign key_held  = held_q;
    assign overflow  = overflow_q;

endmodule
